param_line_engine: RTL
======================

// Module: param_line_engine
// PURPOSE
// Parametrised successor to the Bresenham line engine. It draws a line, or (new) a filled axis-aligned
// rectangle, into the DDR framebuffer through the af/wdf write FIFOs.
// Pixels outside FB_WIDTH x FB_HEIGHT are clipped (new). Consecutive pixels in one 8-pixel block are
// coalesced into a single masked write burst (new).
// Sits between the CPU's memory-mapped LE registers and the DDR request FIFOs.
// PARAMETERS
// COORD_W    10     coordinate width in bits (x and y); must be >= 4
// FB_WIDTH   1024   visible width in pixels; pixels with x >= FB_WIDTH are clipped
// FB_HEIGHT  768    visible height in pixels; pixels with y >= FB_HEIGHT are clipped
// ADDR_W     31     DDR address width
// PORTS
// clk             in   1        system clock; single clock domain
// rst             in   1        synchronous, active-high reset
// LE_ready        out  1        engine idle; accepts register writes and trigger
// LE_color        in   32       pixel colour, 8 bits each for R, G, B
// LE_point        in   COORD_W  coordinate value for the x0/y0/x1/y1 valid strobes
// LE_color_valid  in   1        latch LE_color
// LE_x0_valid     in   1        latch LE_point as x0 (same pattern for y0, x1, y1)
// LE_y0_valid     in   1        latch LE_point as y0
// LE_x1_valid     in   1        latch LE_point as x1
// LE_y1_valid     in   1        latch LE_point as y1
// LE_mode         in   1        sampled on trigger: 0 = line, 1 = filled rectangle
// LE_trigger      in   1        start drawing
// LE_frame_base   in   32       framebuffer base address; block-aligned, OR'd into the address
// af_full         in   1        address FIFO full
// wdf_full        in   1        write-data FIFO full
// af_cmd_din      out  3        always 3'b000 (write)
// af_addr_din     out  ADDR_W   base | {y, x[COORD_W-1:3], 2'b00}
// af_wr_en        out  1        address FIFO push
// wdf_din         out  128      {4{colour}}
// wdf_mask_din    out  16       active-low byte mask; [15:12] = first pixel of the beat
// wdf_wr_en       out  1        write-data FIFO push
// BEHAVIOUR
// - Reset values:
//   - LE_ready = 1.
//   - af_wr_en = wdf_wr_en = 0.
//   - af_addr_din = 0, wdf_din = 0, wdf_mask_din = 16'hFFFF.
//   - All latched registers = 0; state = IDLE.
// - Register strobes are honoured only in IDLE.
//   - A strobe in the same cycle as LE_trigger (e.g. y1_valid) is used by that trigger.
//   - LE_trigger while busy is ignored.
// - States: IDLE -> SETUP -> STEP -> (FLUSH_A -> FLUSH_B) -> STEP ... -> DONE -> IDLE.
//   - Trigger in cycle T: LE_ready = 0 from T+1.
//   - First af_wr_en no earlier than T+3.
//   - LE_ready returns high the cycle after the last FLUSH_B beat.
// - SETUP, line mode (standard Bresenham):
//   - steep = |dy| > |dx|; if steep, swap x and y.
//   - If x0 > x1, swap the endpoints.
//   - err = dx/2; ystep = +/-1. Use COORD_W+1-bit signed arithmetic.
//   - Pixels are emitted from the swapped start point to the end point inclusive.
//   - x0 == x1 and y0 == y1 draws exactly one pixel.
// - SETUP, rectangle mode:
//   - Corners are normalised to min/max.
//   - Rows are filled top to bottom, each row left to right, bounds inclusive.
// - STEP produces one pixel per cycle and sets its bit in an 8-bit block mask (pixel = x[2:0]).
//   - A clipped pixel is dropped; it sets no bit.
//   - The block is flushed when the next pixel has a different {y, x[COORD_W-1:3]}, or after the
//     last pixel.
//   - An all-clear mask is never flushed.
// - FLUSH_A: af_wr_en = wdf_wr_en = 1 with beat 0 (pixels 0-3).
//   - Fires only in a cycle where af_full == 0 and wdf_full == 0.
// - FLUSH_B: wdf_wr_en = 1 with beat 1 (pixels 4-7).
//   - Fires only when wdf_full == 0.
// - While a FLUSH is stalled: enables stay 0, data/addr/mask are held, and STEP does not advance.
// - The mask nibble is 4'h0 for pixels written and 4'hF for pixels skipped.
// - rst mid-draw: the next cycle is IDLE, pending block discarded, enables 0, LE_ready = 1.
// TESTING
// 1. Base 0, line (0,0)-(15,0) colour 0x007F0000, no backpressure:
//    - Exactly 2 bursts, addresses 0x0 then 0x4.
//    - All four beats have mask 16'h0000; LE_ready returns high.
// 2. Line (0x100,0)-(0,0x100):
//    - 257 bursts, each 1 pixel.
//    - Pixel sequence equals the bench Bresenham model, starting at (0,256) and ending at (256,0).
// 3. Test 2 with af_full high 1 of every 3 cycles and random wdf_full:
//    - No push while the relevant FIFO is full.
//    - Identical address/mask/data sequence to test 2.
// 4. FB_HEIGHT=768, line (0,700)-(0,800):
//    - Exactly 68 bursts, for y = 700..767.
//    - Nothing at y >= 768.
// 5. Mode 1, rect (2,5)-(9,6): 4 bursts.
//    - Each row has two bursts: {16'hFF00, 16'h0000} at x-block 0, then {16'h00FF, 16'hFFFF} at x-block 1.
//    - Row 5 first.
// 6. Assert rst for 1 cycle mid-way through test 2:
//    - Enables are 0 the next cycle and LE_ready = 1.
//    - A fresh test 1 then passes.

Source files
------------

// File: rtl/param_line_engine.sv
// param_line_engine: Bresenham line / filled-rectangle rasteriser that clips to the framebuffer
// and coalesces pixels of one 8-pixel block into a single two-beat masked DDR write.
module param_line_engine #(
  parameter int COORD_W = 10,
  parameter int FB_WIDTH = 1024,
  parameter int FB_HEIGHT = 768,
  parameter int ADDR_W = 31
) (
  input  logic               clk,
  input  logic               rst,
  output logic               LE_ready,
  input  logic [31:0]        LE_color,
  input  logic [COORD_W-1:0] LE_point,
  input  logic               LE_color_valid,
  input  logic               LE_x0_valid,
  input  logic               LE_y0_valid,
  input  logic               LE_x1_valid,
  input  logic               LE_y1_valid,
  input  logic               LE_mode,
  input  logic               LE_trigger,
  input  logic [31:0]        LE_frame_base,
  input  logic               af_full,
  input  logic               wdf_full,
  output logic [2:0]         af_cmd_din,
  output logic [ADDR_W-1:0]  af_addr_din,
  output logic               af_wr_en,
  output logic [127:0]       wdf_din,
  output logic [15:0]        wdf_mask_din,
  output logic               wdf_wr_en
);
  localparam int BW = 2 * COORD_W - 3;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  typedef enum logic [2:0] {IDLE, SETUP, STEP, FLUSH_A, FLUSH_B, DONE} state_t;
  state_t state, state_n;
  logic [31:0] color;
  logic [COORD_W-1:0] x0, y0, x1, y1;
  logic rect, steep, yneg, fin;
  logic [COORD_W-1:0] cur_x, cur_y, end_x, end_y, start_x, dx, dy;
  logic signed [COORD_W:0] err, err_d;
  logic [BW-1:0] blk, pblk;
  logic [7:0] mask, nmask, fmask;
  logic [COORD_W-1:0] adx, ady, a0, b0, a1, b1, sa, sb, ea, eb, xmin, xmax, ymin, ymax;
  logic stp, sw;
  logic [COORD_W-1:0] px, py;
  logic vis, last, pend, fire_a, fire_b;
  logic unused_base;
  assign unused_base = ^LE_frame_base;
  always_comb begin
    adx = x1 >= x0 ? x1 - x0 : x0 - x1;
    ady = y1 >= y0 ? y1 - y0 : y0 - y1;
    stp = ady > adx;
    a0 = stp ? y0 : x0;
    b0 = stp ? x0 : y0;
    a1 = stp ? y1 : x1;
    b1 = stp ? x1 : y1;
    sw = a0 > a1;
    sa = sw ? a1 : a0;
    sb = sw ? b1 : b0;
    ea = sw ? a0 : a1;
    eb = sw ? b0 : b1;
    xmin = x0 < x1 ? x0 : x1;
    xmax = x0 < x1 ? x1 : x0;
    ymin = y0 < y1 ? y0 : y1;
    ymax = y0 < y1 ? y1 : y0;
  end
  // cur_x walks the major axis of a line (minor in cur_y); steep lines swap them back on output
  always_comb begin
    px = (!rect && steep) ? cur_y : cur_x;
    py = (!rect && steep) ? cur_x : cur_y;
    pblk = {py, px[COORD_W-1:3]};
    vis = int'(px) < FB_WIDTH && int'(py) < FB_HEIGHT;
    last = cur_x == end_x && (!rect || cur_y == end_y);
    pend = blk != pblk && mask != 8'h0;
    nmask = (blk == pblk ? mask : 8'h0) | (vis ? 8'h01 << px[2:0] : 8'h0);
    fmask = pend ? mask : nmask;
    err_d = err - $signed({1'b0, dy});
    fire_a = state == FLUSH_A && !af_full && !wdf_full;
    fire_b = state == FLUSH_B && !wdf_full;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = LE_trigger ? SETUP : IDLE;
      SETUP:   state_n = STEP;
      STEP:    state_n = (pend || (last && nmask != 8'h0)) ? FLUSH_A : last ? DONE : STEP;
      FLUSH_A: state_n = fire_a ? FLUSH_B : FLUSH_A;
      FLUSH_B: state_n = fire_b ? (fin ? IDLE : STEP) : FLUSH_B;
      default: state_n = IDLE;
    endcase
  end
  assign LE_ready = state == IDLE;
  assign af_cmd_din = 3'b000;
  assign af_wr_en = fire_a;
  assign wdf_wr_en = fire_a || fire_b;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      color <= '0;
      x0 <= '0;
      y0 <= '0;
      x1 <= '0;
      y1 <= '0;
      rect <= 1'b0;
      steep <= 1'b0;
      yneg <= 1'b0;
      fin <= 1'b0;
      cur_x <= '0;
      cur_y <= '0;
      end_x <= '0;
      end_y <= '0;
      start_x <= '0;
      dx <= '0;
      dy <= '0;
      err <= '0;
      blk <= '0;
      mask <= '0;
      af_addr_din <= '0;
      wdf_din <= '0;
      wdf_mask_din <= 16'hFFFF;
    end else begin
      if (state == IDLE) begin
        if (LE_color_valid) color <= LE_color;
        if (LE_x0_valid) x0 <= LE_point;
        if (LE_y0_valid) y0 <= LE_point;
        if (LE_x1_valid) x1 <= LE_point;
        if (LE_y1_valid) y1 <= LE_point;
        if (LE_trigger) rect <= LE_mode;
      end
      if (state == SETUP) begin
        fin <= 1'b0;
        mask <= '0;
        blk <= '0;
        steep <= stp;
        cur_x <= rect ? xmin : sa;
        start_x <= xmin;
        end_x <= rect ? xmax : ea;
        cur_y <= rect ? ymin : sb;
        end_y <= ymax;
        dx <= ea - sa;
        dy <= eb >= sb ? eb - sb : sb - eb;
        yneg <= eb < sb;
        err <= $signed({1'b0, ea - sa}) >>> 1;
      end
      // a pixel in a new block waits here until the pending block has been flushed
      if (state == STEP && !pend) begin
        blk <= pblk;
        mask <= nmask;
        fin <= last;
        if (!last && rect) begin
          cur_x <= cur_x == end_x ? start_x : cur_x + ONE;
          if (cur_x == end_x) cur_y <= cur_y + ONE;
        end
        if (!last && !rect) begin
          cur_x <= cur_x + ONE;
          err <= err_d[COORD_W] ? err_d + $signed({1'b0, dx}) : err_d;
          if (err_d[COORD_W]) cur_y <= yneg ? cur_y - ONE : cur_y + ONE;
        end
      end
      if (state == STEP && state_n == FLUSH_A) begin
        af_addr_din <= ADDR_W'(LE_frame_base) | ADDR_W'({pend ? blk : pblk, 2'b00});
        wdf_din <= {4{color}};
        wdf_mask_din <= {{4{~fmask[0]}}, {4{~fmask[1]}}, {4{~fmask[2]}}, {4{~fmask[3]}}};
      end
      if (fire_a) wdf_mask_din <= {{4{~mask[4]}}, {4{~mask[5]}}, {4{~mask[6]}}, {4{~mask[7]}}};
      if (fire_b) mask <= 8'h0;
    end
  end
endmodule
